// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request/ready handshake, instruction register load.
// Optional memory-timeout recovery is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_write_enable,
  output logic                  instr_valid,
  input  logic                  instr_ack,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  fetch_error,
  output logic [1:0]            dbg_state
);

  // Handshake: mem_req is held high until mem_ready is sampled high at a rising
  // edge; mem_data is taken in that same cycle. instr_valid holds until instr_ack.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_we;
  logic                  r_valid;
  logic                  r_req;
  logic                  r_squash;
  logic                  w_timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wait;
  logic          r_err;

  // Terminal count is the TIMEOUT_CYCLES-th consecutive silent REQ cycle.
  assign w_timeout = (r_state == S_REQ) && !mem_ready &&
                     (r_wait == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || r_state != S_REQ || mem_ready || w_timeout) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign fetch_error = r_err;
`else
  assign w_timeout   = 1'b0 && (TIMEOUT_CYCLES > 0);
  assign fetch_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_we     <= 1'b0;
      r_valid  <= 1'b0;
      r_req    <= 1'b0;
      r_squash <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_valid <= 1'b0;
          if (redirect) r_pc <= redirect_pc;
        end
        S_REQ: begin
          if (mem_ready) begin
            r_req    <= 1'b0;
            r_squash <= 1'b0;
            if (r_squash || redirect) begin
              // Response belongs to a stale PC: drop it and re-request.
              r_state <= S_IDLE;
              if (redirect) r_pc <= redirect_pc;
            end else begin
              r_state <= S_HOLD;
              r_instr <= mem_data;
              r_we    <= 1'b1;
              r_valid <= 1'b1;
              r_pc    <= r_pc + 1'b1;
            end
          end else if (w_timeout) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_squash <= 1'b0;
            if (redirect) r_pc <= redirect_pc;
          end else if (redirect) begin
            r_pc     <= redirect_pc;
            r_squash <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || instr_ack) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
            if (redirect) r_pc <= redirect_pc;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req            = r_req;
  assign mem_addr           = r_pc;
  assign pc                 = r_pc;
  assign instr              = r_instr;
  assign instr_write_enable = r_we;
  assign instr_valid        = r_valid;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; write pulses are checked against a queue of expected words.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic        instr_write_enable;
  logic        instr_valid;
  logic        instr_ack;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] pc;
  logic        fetch_error;
  logic [1:0]  dbg_state;

  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_we  = 0;
  int n_push = 0;
  int we_mark;

  fetch_unit #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(16'h0000), .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data),
    .instr(instr), .instr_write_enable(instr_write_enable),
    .instr_valid(instr_valid), .instr_ack(instr_ack),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .fetch_error(fetch_error), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [15:0] data, input bit expect_load);
    mem_ready = 1'b1;
    mem_data  = data;
    if (expect_load) begin
      exp_q.push_back(data);
      n_push++;
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (instr_write_enable === 1'b1) begin
      n_we++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL wr_unexpected: observed instr %0h expected no write", instr);
      end else begin
        chk("wr_data", {16'h0, instr}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; mem_data = '0; instr_ack = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    step(); step();
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_we", instr_write_enable, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_err", fetch_error, 0);

    // Zero-wait first fetch
    reset = 1'b0;
    step();
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 0);
    present(16'h1234, 1);
    step();
    mem_ready = 1'b0;
    chk("t1_we", instr_write_enable, 1);
    chk("t1_valid", instr_valid, 1);
    chk("t1_instr", instr, 16'h1234);
    chk("t1_pc", pc, 1);
    chk("t1_req_low", mem_req, 0);
    step();
    chk("t1_we_once", instr_write_enable, 0);

    // Three wait cycles
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    we_mark = n_we;
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", mem_req, 1);
      chk("t2_addr", mem_addr, 1);
      chk("t2_no_we", instr_write_enable, 0);
      if (i == 3) present(16'hABCD, 1);
      step();
    end
    mem_ready = 1'b0;
    chk("t2_we", instr_write_enable, 1);
    chk("t2_pc", pc, 2);
    step();
    chk("t2_one_pulse", n_we - we_mark, 1);

    // Hold without ack
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_valid", instr_valid, 1);
      chk("t3_no_req", mem_req, 0);
      chk("t3_pc", pc, 2);
      chk("t3_instr", instr, 16'hABCD);
    end
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    chk("t3_req", mem_req, 1);
    chk("t3_addr", mem_addr, 2);
    chk("t3_valid_drop", instr_valid, 0);
    present(16'h5555, 1);
    step();
    mem_ready = 1'b0;
    chk("t3_pc_next", pc, 3);

    // Redirect during a 2-wait request
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    chk("t4_addr_old", mem_addr, 3);
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    chk("t4_req_held", mem_req, 1);
    chk("t4_pc", pc, 16'h0040);
    step();
    we_mark = n_we;
    present(16'hDEAD, 0);
    step();
    mem_ready = 1'b0;
    chk("t4_no_we", instr_write_enable, 0);
    chk("t4_req_idle", mem_req, 0);
    step();
    chk("t4_req_new", mem_req, 1);
    chk("t4_addr_new", mem_addr, 16'h0040);
    chk("t4_no_pulse", n_we - we_mark, 0);
    present(16'h4040, 1);
    step();
    mem_ready = 1'b0;
    chk("t4_pc_next", pc, 16'h0041);

    // Redirect in HOLD to the top address, then wrap
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    chk("t5_valid_drop", instr_valid, 0);
    chk("t5_addr", mem_addr, 16'hFFFF);
    present(16'h0F0F, 1);
    step();
    mem_ready = 1'b0;
    chk("t5_wrap", pc, 0);
    // Redirect coincident with ack
    instr_ack = 1'b1; redirect = 1'b1; redirect_pc = 16'h0123;
    step();
    instr_ack = 1'b0; redirect = 1'b0;
    chk("t5_redir_addr", mem_addr, 16'h0123);
    chk("t5_redir_req", mem_req, 1);
    present(16'h7777, 1);
    step();
    mem_ready = 1'b0;
    chk("t5_pc_next", pc, 16'h0124);

    // Redirect in the same cycle as mem_ready
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    present(16'hBAD0, 0);
    redirect = 1'b1; redirect_pc = 16'h0200;
    step();
    mem_ready = 1'b0; redirect = 1'b0;
    chk("t6_no_we", instr_write_enable, 0);
    chk("t6_pc", pc, 16'h0200);
    step();
    chk("t6_req", mem_req, 1);
    chk("t6_addr", mem_addr, 16'h0200);

    // Silent memory for 15 request cycles
    for (int i = 0; i < 14; i++) step();
    chk("t7_err_pre", fetch_error, 0);
    step();
`ifdef FETCH_TIMEOUT_EN
    chk("t7_req_drop", mem_req, 0);
    chk("t7_err", fetch_error, 1);
    chk("t7_pc", pc, 16'h0200);
    step();
    chk("t7_rereq", mem_req, 1);
    chk("t7_readdr", mem_addr, 16'h0200);
    chk("t7_err_sticky", fetch_error, 1);
`else
    chk("t7_req_held", mem_req, 1);
    chk("t7_no_err", fetch_error, 0);
    step();
    chk("t7_req_held2", mem_req, 1);
    chk("t7_addr", mem_addr, 16'h0200);
`endif
    present(16'h1111, 1);
    step();
    mem_ready = 1'b0;
    chk("t7_pc_next", pc, 16'h0201);

    // Reset in the middle of a response
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    present(16'h9999, 0);
    reset = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("t8_req", mem_req, 0);
    chk("t8_we", instr_write_enable, 0);
    chk("t8_pc", pc, 0);
    chk("t8_instr", instr, 0);
    chk("t8_valid", instr_valid, 0);
    chk("t8_err", fetch_error, 0);
    step();
    reset = 1'b0;
    step();
    chk("t8_req_again", mem_req, 1);
    chk("t8_addr", mem_addr, 0);

    step(); step();
    chk("sb_drained", exp_q.size(), 0);
    chk("sb_pulses", n_we, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
